// File: rtl/axis_video_coord_pipe.sv
// axis_video_coord_pipe: elastic AXI4-Stream video register pipeline that tags
// every beat with the raster coordinate (x, y) of its first pixel and raises
// sticky flags for lines that end early or run past active_width.
// Optional build macro: AXIS_COORD_FRAME_STATS_EN adds frame_count and
// line_count_last outputs.
module axis_video_coord_pipe #(
  parameter int DATA_W          = 64,
  parameter int PIXELS_PER_BEAT = 2,
  parameter int STAGES          = 2,
  parameter int COORD_W         = 12
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               aclken,
  input  logic               SW_RESET,
  input  logic [COORD_W-1:0] active_width,
  input  logic [DATA_W-1:0]  s_axis_video_tdata_in,
  input  logic               s_axis_video_tvalid_in,
  output logic               s_axis_video_tready_out,
  input  logic               s_axis_video_tuser_in,
  input  logic               s_axis_video_tlast_in,
  output logic [DATA_W-1:0]  s_axis_video_tdata_out,
  output logic               s_axis_video_tvalid_out,
  input  logic               s_axis_video_tready_in,
  output logic               s_axis_video_tuser_out,
  output logic               s_axis_video_tlast_out,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               err_eol_early,
  output logic               err_eol_late
`ifdef AXIS_COORD_FRAME_STATS_EN
  ,
  output logic [31:0]        frame_count,
  output logic [COORD_W-1:0] line_count_last
`endif
);

  localparam logic [COORD_W:0] PPB_EXT = (COORD_W+1)'(PIXELS_PER_BEAT);

  logic [STAGES-1:0]  vld;
  logic [STAGES-1:0]  user_q;
  logic [STAGES-1:0]  last_q;
  logic [DATA_W-1:0]  data_q [STAGES];
  logic [COORD_W-1:0] x_q    [STAGES];
  logic [COORD_W-1:0] y_q    [STAGES];

  // load[i]: stage i may capture this cycle (it is empty or its content moves on)
  logic [STAGES-1:0]  load;
  logic               full_from;
  logic               accept;

  logic [COORD_W-1:0] x_cnt;
  logic [COORD_W-1:0] y_cnt;
  logic [COORD_W-1:0] beat_x;
  logic [COORD_W-1:0] beat_y;
  logic [COORD_W:0]   x_end;
  logic               early_hit;
  logic               late_hit;

  // Ready chain: a stage can load unless it and every stage after it is full
  // and the downstream consumer is stalled. Expanded per stage to keep the
  // chain free of combinational self-reference.
  always_comb begin
    load      = '0;
    full_from = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      full_from = 1'b1;
      for (int j = i; j < STAGES; j++) begin
        full_from = full_from & vld[j];
      end
      load[i] = s_axis_video_tready_in | ~full_from;
    end
  end

  assign s_axis_video_tready_out = aresetn & aclken & ~SW_RESET & load[0];
  assign accept = s_axis_video_tvalid_in & s_axis_video_tready_out;

  // Coordinate of the beat being accepted; SOF forces the origin.
  always_comb begin
    beat_x    = s_axis_video_tuser_in ? '0 : x_cnt;
    beat_y    = s_axis_video_tuser_in ? '0 : y_cnt;
    x_end     = {1'b0, beat_x} + PPB_EXT;
    early_hit = (active_width != '0) && s_axis_video_tlast_in &&
                (x_end < {1'b0, active_width});
    late_hit  = (active_width != '0) && !s_axis_video_tlast_in &&
                (x_end >= {1'b0, active_width});
  end

  // Raster counters and sticky line-length error flags.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      x_cnt         <= '0;
      y_cnt         <= '0;
      err_eol_early <= 1'b0;
      err_eol_late  <= 1'b0;
    end else if (aclken) begin
      if (SW_RESET) begin
        x_cnt         <= '0;
        y_cnt         <= '0;
        err_eol_early <= 1'b0;
        err_eol_late  <= 1'b0;
      end else if (accept) begin
        if (s_axis_video_tlast_in) begin
          x_cnt <= '0;
          y_cnt <= beat_y + COORD_W'(1);
        end else begin
          x_cnt <= x_end[COORD_W-1:0];
          y_cnt <= beat_y;
        end
        err_eol_early <= err_eol_early | early_hit;
        err_eol_late  <= err_eol_late  | late_hit;
      end
    end
  end

  // Elastic register slices: payload only captured alongside a valid beat so
  // held output never changes while the downstream stalls.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld    <= '0;
      user_q <= '0;
      last_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
        x_q[i]    <= '0;
        y_q[i]    <= '0;
      end
    end else if (aclken) begin
      if (SW_RESET) begin
        vld <= '0;
      end else begin
        if (load[0]) begin
          vld[0] <= s_axis_video_tvalid_in;
          if (s_axis_video_tvalid_in) begin
            data_q[0] <= s_axis_video_tdata_in;
            user_q[0] <= s_axis_video_tuser_in;
            last_q[0] <= s_axis_video_tlast_in;
            x_q[0]    <= beat_x;
            y_q[0]    <= beat_y;
          end
        end
        for (int i = 1; i < STAGES; i++) begin
          if (load[i]) begin
            vld[i] <= vld[i-1];
            if (vld[i-1]) begin
              data_q[i] <= data_q[i-1];
              user_q[i] <= user_q[i-1];
              last_q[i] <= last_q[i-1];
              x_q[i]    <= x_q[i-1];
              y_q[i]    <= y_q[i-1];
            end
          end
        end
      end
    end
  end

  assign s_axis_video_tvalid_out = vld[STAGES-1];
  assign s_axis_video_tdata_out  = data_q[STAGES-1];
  assign s_axis_video_tuser_out  = user_q[STAGES-1];
  assign s_axis_video_tlast_out  = last_q[STAGES-1];
  assign x_out                   = x_q[STAGES-1];
  assign y_out                   = y_q[STAGES-1];

`ifdef AXIS_COORD_FRAME_STATS_EN
  // Frame statistics: count SOF beats and remember the line count they close.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_count     <= '0;
      line_count_last <= '0;
    end else if (aclken) begin
      if (SW_RESET) begin
        frame_count     <= '0;
        line_count_last <= '0;
      end else if (accept && s_axis_video_tuser_in) begin
        frame_count     <= frame_count + 32'd1;
        line_count_last <= y_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axis_video_coord_pipe.sv
// Scoreboard bench for axis_video_coord_pipe: directed beats carry their
// hand-computed coordinates; a monitor checks every emitted beat.
module tb_axis_video_coord_pipe;

  localparam int DW = 64;
  localparam int CW = 12;
  localparam int ST = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          aclken;
  logic          sw_reset;
  logic [CW-1:0] aw;
  logic [DW-1:0] tdata_in;
  logic          tvalid_in;
  logic          tready_out;
  logic          tuser_in;
  logic          tlast_in;
  logic [DW-1:0] tdata_out;
  logic          tvalid_out;
  logic          tready_in;
  logic          tuser_out;
  logic          tlast_out;
  logic [CW-1:0] x_out;
  logic [CW-1:0] y_out;
  logic          err_e;
  logic          err_l;
`ifdef AXIS_COORD_FRAME_STATS_EN
  logic [31:0]   frame_count;
  logic [CW-1:0] line_count_last;
`endif

  axis_video_coord_pipe #(
    .DATA_W(DW), .PIXELS_PER_BEAT(2), .STAGES(ST), .COORD_W(CW)
  ) dut (
    .aclk                   (clk),
    .aresetn                (rst_n),
    .aclken                 (aclken),
    .SW_RESET               (sw_reset),
    .active_width           (aw),
    .s_axis_video_tdata_in  (tdata_in),
    .s_axis_video_tvalid_in (tvalid_in),
    .s_axis_video_tready_out(tready_out),
    .s_axis_video_tuser_in  (tuser_in),
    .s_axis_video_tlast_in  (tlast_in),
    .s_axis_video_tdata_out (tdata_out),
    .s_axis_video_tvalid_out(tvalid_out),
    .s_axis_video_tready_in (tready_in),
    .s_axis_video_tuser_out (tuser_out),
    .s_axis_video_tlast_out (tlast_out),
    .x_out                  (x_out),
    .y_out                  (y_out),
    .err_eol_early          (err_e),
    .err_eol_late           (err_l)
`ifdef AXIS_COORD_FRAME_STATS_EN
    ,
    .frame_count            (frame_count),
    .line_count_last        (line_count_last)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          u;
    logic          l;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    int            acc;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   fails   = 0;
  int   cyc     = 0;
  bit   lat_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every emitted beat is compared with the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && aclken && tvalid_out && tready_in) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_beat: got data %0h with empty scoreboard", tdata_out);
      end else begin
        e = sb.pop_front();
        if (tdata_out !== e.d || tuser_out !== e.u || tlast_out !== e.l ||
            x_out !== e.x || y_out !== e.y) begin
          fails++;
          $display("FAIL beat: got d=%0h u=%0b l=%0b x=%0d y=%0d expected d=%0h u=%0b l=%0b x=%0d y=%0d",
                   tdata_out, tuser_out, tlast_out, x_out, y_out, e.d, e.u, e.l, e.x, e.y);
        end
        if (lat_chk) begin
          checks++;
          if (cyc - e.acc != ST) begin
            fails++;
            $display("FAIL latency: got %0d cycles expected %0d", cyc - e.acc, ST);
          end
        end
      end
    end
  end

  // Present one beat, wait (bounded) for acceptance, push its expected value.
  task automatic send(input logic [DW-1:0] d, input logic u, input logic l,
                      input logic [CW-1:0] ex, input logic [CW-1:0] ey);
    int   n = 0;
    exp_t e;
    tdata_in  = d;
    tuser_in  = u;
    tlast_in  = l;
    tvalid_in = 1'b1;
    @(negedge clk);
    while (!(tready_out && aclken) && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: got no tready_out for data %0h expected acceptance", d);
    end else begin
      if (lat_chk) begin
        checks++;
        if (n != 0) begin
          fails++;
          $display("FAIL stall: got %0d wait cycles expected 0", n);
        end
      end
      e.d = d; e.u = u; e.l = l; e.x = ex; e.y = ey; e.acc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tvalid_in = 1'b0;
    tuser_in  = 1'b0;
    tlast_in  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] held;
    rst_n = 1'b0; aclken = 1'b1; sw_reset = 1'b0; aw = 12'd8;
    tdata_in = '0; tvalid_in = 1'b0; tuser_in = 1'b0; tlast_in = 1'b0;
    tready_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(tvalid_out), 64'd0);
    chk("rst_tready", 64'(tready_out), 64'd0);
    chk("rst_tdata",  tdata_out, 64'd0);
    chk("rst_x",      64'(x_out), 64'd0);
    chk("rst_y",      64'(y_out), 64'd0);
    chk("rst_errs",   64'({err_e, err_l}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 64'(tready_out), 64'd1);

    // One 4-beat line
    lat_chk = 1'b1;
    send(64'h100, 1, 0, 0, 0);
    send(64'h101, 0, 0, 2, 0);
    send(64'h102, 0, 0, 4, 0);
    send(64'h103, 0, 1, 6, 0);
    idle();
    drain();
    chk("t1_errs", 64'({err_e, err_l}), 64'd0);

    // Three lines back to back, then a new frame
    for (int l = 0; l < 3; l++)
      for (int b = 0; b < 4; b++)
        send(64'h200 + 64'(l*4 + b), (l == 0 && b == 0), (b == 3), CW'(b*2), CW'(l));
    send(64'h2FF, 1, 0, 0, 0);
    send(64'h2FE, 0, 0, 2, 0);
    idle();
    drain();
    chk("t2_errs", 64'({err_e, err_l}), 64'd0);

    // Backpressure: two beats fill the pipe, then ready drops
    lat_chk = 1'b0;
    tready_in = 1'b0;
    send(64'h300, 1, 0, 0, 0);
    send(64'h301, 0, 0, 2, 0);
    tvalid_in = 1'b1;
    @(negedge clk);
    chk("bp_tready", 64'(tready_out), 64'd0);
    chk("bp_tvalid", 64'(tvalid_out), 64'd1);
    chk("bp_data",   tdata_out, 64'h300);
    held = tdata_out;
    repeat (2) @(negedge clk);
    chk("bp_hold_data",  tdata_out, held);
    chk("bp_hold_tready", 64'(tready_out), 64'd0);
    @(posedge clk); #1;
    fork
      begin
        repeat (2) @(posedge clk);
        #1 tready_in = 1'b1;
      end
    join_none
    send(64'h302, 0, 0, 4, 0);
    send(64'h303, 0, 1, 6, 0);
    idle();
    drain();

    // Early and late end-of-line errors
    tready_in = 1'b1;
    lat_chk = 1'b1;
    send(64'h400, 1, 0, 0, 0);
    send(64'h401, 0, 0, 2, 0);
    send(64'h402, 0, 1, 4, 0);
    idle();
    @(negedge clk);
    chk("early_set", 64'(err_e), 64'd1);
    chk("late_clear", 64'(err_l), 64'd0);
    @(posedge clk); #1;
    send(64'h410, 0, 0, 0, 1);
    send(64'h411, 0, 0, 2, 1);
    send(64'h412, 0, 0, 4, 1);
    send(64'h413, 0, 0, 6, 1);
    idle();
    @(negedge clk);
    chk("late_set", 64'(err_l), 64'd1);
    chk("early_sticky", 64'(err_e), 64'd1);
    @(posedge clk); #1;
    send(64'h414, 0, 1, 8, 1);
    idle();
    drain();

    // SW_RESET flush with two beats in flight
    lat_chk = 1'b0;
    tready_in = 1'b0;
    send(64'h500, 0, 0, 0, 2);
    send(64'h501, 0, 0, 2, 2);
    idle();
    sw_reset = 1'b1;
    @(negedge clk);
    chk("swr_tready", 64'(tready_out), 64'd0);
    @(posedge clk); #1;
    sw_reset = 1'b0;
    sb.delete();
    chk("swr_tvalid", 64'(tvalid_out), 64'd0);
    chk("swr_errs", 64'({err_e, err_l}), 64'd0);
    sw_reset = 1'b1;
    @(negedge clk);
    chk("swr_tready_empty", 64'(tready_out), 64'd0);
    @(posedge clk); #1;
    sw_reset = 1'b0;
    tready_in = 1'b1;
    lat_chk = 1'b1;
    send(64'h510, 0, 0, 0, 0);
    send(64'h511, 0, 0, 2, 0);
    idle();
    drain();

    // Clock-enable gap with a beat held at the output
    lat_chk = 1'b0;
    send(64'h600, 1, 0, 0, 0);
    send(64'h601, 0, 0, 2, 0);
    idle();
    aclken = 1'b0;
    @(negedge clk);
    chk("ce_tready", 64'(tready_out), 64'd0);
    chk("ce_tvalid", 64'(tvalid_out), 64'd1);
    chk("ce_data",   tdata_out, 64'h600);
    repeat (3) @(negedge clk);
    chk("ce_hold_tvalid", 64'(tvalid_out), 64'd1);
    chk("ce_hold_data",   tdata_out, 64'h600);
    @(posedge clk); #1;
    aclken = 1'b1;
    send(64'h602, 0, 0, 4, 0);
    send(64'h603, 0, 1, 6, 0);
    idle();
    drain();

    // Asynchronous reset mid-frame
    tready_in = 1'b0;
    send(64'h700, 0, 0, 0, 1);
    send(64'h701, 0, 1, 2, 1);
    idle();
    chk("pre_rst_early", 64'(err_e), 64'd1);
    chk("pre_rst_y", 64'(y_out), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_tvalid", 64'(tvalid_out), 64'd0);
    chk("arst_tready", 64'(tready_out), 64'd0);
    chk("arst_data",   tdata_out, 64'd0);
    chk("arst_y",      64'(y_out), 64'd0);
    chk("arst_errs",   64'({err_e, err_l}), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    tready_in = 1'b1;
    lat_chk = 1'b1;
    send(64'h710, 0, 0, 0, 0);
    idle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/axis_video_coord_pipe.md
Name: axis_video_coord_pipe

Overview:
- Parametrised AXI4-Stream video register pipeline; next generation of the Keystone input stage.
- Carries tdata/tuser/tlast through STAGES elastic register slices with full backpressure.
- Tags every beat with the raster coordinate (x, y) of its first pixel and flags malformed lines.
- Sits between the video DMA/VDMA stream and the homography datapath, which consumes x/y directly.

Parameters:
- DATA_W, 64, tdata width in bits.
- PIXELS_PER_BEAT, 2, pixels per beat; x advances by this amount per accepted beat.
- STAGES, 2, register slices (>=1); the latency with no backpressure.
- COORD_W, 12, width of the x/y counters and the active_width input.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- aclken  in  1  clock enable; low freezes all state
- SW_RESET  in  1  synchronous flush, active-high
- active_width  in  COORD_W  expected pixels per line
- s_axis_video_tdata_in  in  DATA_W  input data
- s_axis_video_tvalid_in  in  1  input valid
- s_axis_video_tready_out  out  1  input ready
- s_axis_video_tuser_in  in  1  start of frame (SOF)
- s_axis_video_tlast_in  in  1  end of line (EOL)
- s_axis_video_tdata_out  out  DATA_W  output data
- s_axis_video_tvalid_out  out  1  output valid
- s_axis_video_tready_in  in  1  downstream ready
- s_axis_video_tuser_out  out  1  SOF out
- s_axis_video_tlast_out  out  1  EOL out
- x_out  out  COORD_W  x of first pixel in the output beat
- y_out  out  COORD_W  line number of the output beat
- err_eol_early  out  1  sticky: tlast arrived before active_width pixels
- err_eol_late  out  1  sticky: active_width reached without tlast

Behaviour:
- Reset (async, aresetn=0):
  - All stage valids are 0; tvalid_out=0; tready_out=0 while in reset.
  - x/y counters are 0; both err flags are 0.
  - tdata/tuser/tlast/x_out/y_out outputs are 0.
- Handshake:
  - A beat is accepted when tvalid_in && tready_out && aclken.
  - A beat is emitted when tvalid_out && tready_in && aclken.
  - Once tvalid_out is high, it and all output payload hold stable until the beat is taken.
- Elastic slices:
  - Stage i loads when !valid[i] || advance[i+1], where advance[STAGES] = tready_in.
  - tready_out = !valid[0] || advance[1] (combinational ready chain, no bubbles).
  - Latency is STAGES cycles from acceptance to tvalid_out with tready_in=1.
  - Sustained throughput is 1 beat/cycle.
  - With tready_in=0, the pipe fills STAGES beats, then tready_out=0.
- Coordinates (computed at acceptance, carried with the beat):
  - Beat with tuser=1: x=0, y=0; tuser overrides any pending position.
  - Otherwise the beat takes the current counters.
  - After the beat: if tlast, then x:=0 and y:=y+1; else x:=x+PIXELS_PER_BEAT.
  - Counters wrap modulo 2^COORD_W with no error.
- Error flags (set at acceptance, sticky until aresetn or SW_RESET):
  - err_eol_early: tlast && (x+PIXELS_PER_BEAT) < active_width.
  - err_eol_late: !tlast && (x+PIXELS_PER_BEAT) >= active_width.
  - The next beat after an error continues normally: x resets only on tlast/tuser.
- aclken=0:
  - No register changes.
  - tready_out forced 0; outputs hold.
- SW_RESET=1 (sampled with aclken=1):
  - Next edge clears all valids, counters and err flags; in-flight beats are dropped.
  - tready_out=0 during the SW_RESET cycle.
- Simultaneous accept and emit in one cycle: both occur; occupancy is unchanged.
- active_width=0: err checks disabled (both flags stay 0).

Optional Feature:
- Macro: AXIS_COORD_FRAME_STATS_EN.
- When defined, adds outputs frame_count (32b, increments on each accepted tuser beat) and line_count_last (COORD_W, y value at the most recent SOF, i.e. lines in the previous frame).
  - Both reset to 0 on aresetn/SW_RESET and freeze when aclken=0.
- When not defined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then a 4-beat line (active_width=8, PPB=2) with SOF on beat0 and tlast on beat3, tready_in=1 -> outputs appear STAGES=2 cycles later; x_out=0,2,4,6, y_out=0; tuser_out only on beat0; no errors.
- Continuous 3 lines of 4 beats, then SOF -> y_out=0,1,2 then back to 0 on the SOF beat; 1 beat/cycle with no bubbles.
- Hold tready_in=0 for 5 cycles while streaming -> tready_out drops after exactly 2 accepted beats; payload stable; release gives in-order output with no loss or duplication.
- tlast on beat2 with active_width=8 -> err_eol_early=1 and stays set; an 8-pixel line with no tlast -> err_eol_late=1.
- Assert SW_RESET with 2 beats in flight -> tvalid_out=0 next cycle; counters at 0; flags cleared; the next accepted beat has x_out=0, y_out=0.
- aclken=0 for 3 cycles mid-stream, and async aresetn pulse mid-frame -> no state change during the clock-enable gap; on reset all outputs are 0 immediately.
